rr_lock_arbiter: RTL and testbench
==================================

// Module: rr_lock_arbiter
// PURPOSE
//  Two-requester round-robin arbiter sharing one registered 32-bit output slot (valid/ready).
//  Grant sequencing has a data->control path: the MSB of an accepted beat can lock the grant
//  to its source. Serves as the sequencing/sharing controller and CellIFT taint test case
//  for the registered data path (data->output register, data->control, control buffering).
// PARAMETERS
//  DATA_W    32  width of request/output data; bit DATA_W-1 is the lock-request bit
//  CNT_W     8   width of the accepted-beat counter (saturating)
//  LOCK_MAX  4   max consecutive locked grants to one source before forced release (>=1)
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous reset, active-low
//  req0_valid   in   1        requester 0 has a beat
//  req0_data    in   DATA_W   requester 0 beat
//  req0_ready   out  1        requester 0 beat accepted this cycle (valid&ready)
//  req1_valid   in   1        requester 1 has a beat
//  req1_data    in   DATA_W   requester 1 beat
//  req1_ready   out  1        requester 1 beat accepted this cycle
//  out_data     out  DATA_W   registered output beat
//  out_valid    out  1        out_data holds a beat
//  out_ready    in   1        consumer takes beat when out_valid&out_ready
//  out_src      out  1        source of current out_data (0/1)
//  locked       out  1        grant currently locked (state != IDLE)
//  beat_count   out  CNT_W    accepted beats since reset, saturating
// BEHAVIOUR
//  Reset (rst=0, async): out_valid=0, out_data=0, out_src=0, beat_count=0, state=IDLE,
//   lock_cnt=0, last_grant=1 (req0 wins first tie). Beat in slot is dropped; any mid-lock
//   state is cleared. req*_ready are 0 while in reset.
//  Slot: can_accept = !out_valid | out_ready. Single entry; accept and drain in same cycle
//   allowed -> 1 beat/cycle sustained throughput.
//  Grant (combinational, from current state): 
//   IDLE: both valid -> source != last_grant; one valid -> that one; none -> no grant.
//   LOCKn: reqn_valid -> grant n only (other requester stalls even if valid);
//          !reqn_valid -> no lock hold, fall back to IDLE arbitration this cycle, state->IDLE.
//  reqN_ready = can_accept & grant==N; never both 1. Ready may depend on valid (no comb
//   path from ready to valid required of requesters).
//  Accept (valid&ready of source g): next cycle out_data=reqg_data, out_src=g, out_valid=1,
//   last_grant=g, beat_count+=1 (holds at 2^CNT_W-1). Latency: accept edge -> out_valid 1 cycle.
//  No accept & out_ready & out_valid: out_valid->0; out_data/out_src hold last value.
//  Lock FSM (updates only on accept of source g):
//   data MSB=1 and lock_cnt+1 < LOCK_MAX: state=LOCKg, lock_cnt+=1 (reset to 1 if g differs
//     from current lock owner or state was IDLE).
//   data MSB=1 and count would reach LOCK_MAX: forced release, state=IDLE, lock_cnt=0;
//     last_grant=g so other requester wins next tie.
//   data MSB=0: state=IDLE, lock_cnt=0.
//  LOCK_MAX=1: lock never taken (every locked beat is a forced release).
//  locked = (state!=IDLE). Backpressure (out_ready=0, out_valid=1): no accepts, FSM holds.
// TESTING
//  1 Reset then req0/req1 valid together, data 0x1,0x2, out_ready=1 -> out 0x1(src0) then
//    0x2(src1), alternating each cycle; beat_count 1,2,...
//  2 req0 sends 0x80000001 x6 with req1 valid, LOCK_MAX=4 -> 3 req0 beats while locked=1,
//    4th req0 beat forces release, next grant req1; locked back to 0.
//  3 Lock owner drops valid one cycle -> req1 granted that cycle, locked=0 afterwards.
//  4 out_ready=0 for 5 cycles with out_valid=1 -> out_data stable, req*_ready=0, count stable;
//    release -> drain and new accept in the same cycle.
//  5 rst low mid-lock with beat in slot -> out_valid=0, locked=0, beat_count=0 immediately
//    (async); after release first tie goes to req0.
//  6 CNT_W=2, 5 accepted beats -> beat_count sequence 1,2,3,3,3.

Source files
------------

// File: rtl/rr_lock_arbiter.sv
// Two-requester round-robin arbiter feeding one registered output slot.
// An accepted beat with its MSB set can lock the grant to its source for up to LOCK_MAX-1 follow-ups.
module rr_lock_arbiter #(
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_src,
  output logic              locked,
  output logic [CNT_W-1:0]  beat_count
);

  localparam int LCW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOCK0, S_LOCK1} state_t;

  state_t            r_state;
  logic [LCW-1:0]    r_lock_cnt;
  logic              r_last_grant;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_out_src;
  logic [CNT_W-1:0]  r_beat_count;

  logic              w_can_accept;
  logic              w_lock_hold;
  logic              w_gnt_vld;
  logic              w_gnt;
  logic              w_accept;
  logic [DATA_W-1:0] w_acc_data;
  logic              w_same_owner;
  logic [LCW-1:0]    w_next_lcnt;

  assign w_can_accept = !r_out_valid || out_ready;
  assign w_lock_hold  = (r_state == S_LOCK0 && req0_valid) ||
                        (r_state == S_LOCK1 && req1_valid);

  // A lock whose owner has nothing to send falls straight back to round-robin.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = 1'b0;
    if (w_lock_hold) begin
      w_gnt_vld = 1'b1;
      w_gnt     = (r_state == S_LOCK1);
    end else if (req0_valid && req1_valid) begin
      w_gnt_vld = 1'b1;
      w_gnt     = ~r_last_grant;
    end else if (req0_valid) begin
      w_gnt_vld = 1'b1;
      w_gnt     = 1'b0;
    end else if (req1_valid) begin
      w_gnt_vld = 1'b1;
      w_gnt     = 1'b1;
    end
  end

  assign w_accept     = rst && w_can_accept && w_gnt_vld;
  assign req0_ready   = w_accept && !w_gnt;
  assign req1_ready   = w_accept && w_gnt;
  assign w_acc_data   = w_gnt ? req1_data : req0_data;
  assign w_same_owner = w_gnt ? (r_state == S_LOCK1) : (r_state == S_LOCK0);
  assign w_next_lcnt  = w_same_owner ? r_lock_cnt + 1'b1 : LCW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_lock_cnt   <= '0;
      r_last_grant <= 1'b1;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_src    <= 1'b0;
      r_beat_count <= '0;
    end else begin
      if (w_accept) begin
        r_out_data   <= w_acc_data;
        r_out_src    <= w_gnt;
        r_out_valid  <= 1'b1;
        r_last_grant <= w_gnt;
        if (r_beat_count != {CNT_W{1'b1}})
          r_beat_count <= r_beat_count + 1'b1;
        // Reaching LOCK_MAX is a forced release; last_grant then hands the next tie away.
        if (w_acc_data[DATA_W-1] && (w_next_lcnt < LCW'(LOCK_MAX))) begin
          r_state    <= w_gnt ? S_LOCK1 : S_LOCK0;
          r_lock_cnt <= w_next_lcnt;
        end else begin
          r_state    <= S_IDLE;
          r_lock_cnt <= '0;
        end
      end else begin
        if (r_out_valid && out_ready)
          r_out_valid <= 1'b0;
        if (w_can_accept && r_state != S_IDLE) begin
          r_state    <= S_IDLE;
          r_lock_cnt <= '0;
        end
      end
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign out_src    = r_out_src;
  assign locked     = (r_state != S_IDLE);
  assign beat_count = r_beat_count;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter: per-cycle reference model plus hand-computed literal checks.
// Three instances share stimulus: default, CNT_W=2 (saturation) and LOCK_MAX=1 (lock never held).
module tb_rr_lock_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0, ordy = 1'b1;
  logic [31:0] d0 = '0, d1 = '0;

  logic        r0, r1, ov, os, lk;
  logic [31:0] od;
  logic [7:0]  bc;
  logic        s_r0, s_r1, s_ov, s_os, s_lk;
  logic [31:0] s_od;
  logic [1:0]  s_bc;
  logic        o_r0, o_r1, o_ov, o_os, o_lk;
  logic [31:0] o_od;
  logic [7:0]  o_bc;

  always #5 clk = ~clk;

  rr_lock_arbiter #(.DATA_W(32), .CNT_W(8), .LOCK_MAX(4)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
    .out_data(od), .out_valid(ov), .out_ready(ordy), .out_src(os),
    .locked(lk), .beat_count(bc));

  rr_lock_arbiter #(.DATA_W(32), .CNT_W(2), .LOCK_MAX(4)) u_small (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_data(d0), .req0_ready(s_r0),
    .req1_valid(v1), .req1_data(d1), .req1_ready(s_r1),
    .out_data(s_od), .out_valid(s_ov), .out_ready(ordy), .out_src(s_os),
    .locked(s_lk), .beat_count(s_bc));

  rr_lock_arbiter #(.DATA_W(32), .CNT_W(8), .LOCK_MAX(1)) u_one (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_data(d0), .req0_ready(o_r0),
    .req1_valid(v1), .req1_data(d1), .req1_ready(o_r1),
    .out_data(o_od), .out_valid(o_ov), .out_ready(ordy), .out_src(o_os),
    .locked(o_lk), .beat_count(o_bc));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: lock owner (-1 = none), run length, last winner, slot contents, beat total.
  int          m_owner = -1, m_runs = 0, m_last = 1, m_valid = 0, m_src = 0, m_cnt = 0;
  logic [31:0] m_data = '0;
  int          c_g, c_n;
  bit          c_acc;
  logic [31:0] c_d;

  always @(negedge clk) begin
    if (!rst) begin
      m_owner = -1; m_runs = 0; m_last = 1; m_valid = 0; m_src = 0; m_cnt = 0; m_data = '0;
    end
    c_g = -1;
    if (m_owner == 0 && v0)      c_g = 0;
    else if (m_owner == 1 && v1) c_g = 1;
    else if (v0 && v1)           c_g = 1 - m_last;
    else if (v0)                 c_g = 0;
    else if (v1)                 c_g = 1;
    c_acc = rst && (m_valid == 0 || ordy) && c_g >= 0;

    check("req0_ready", 32'(r0), 32'(c_acc && c_g == 0));
    check("req1_ready", 32'(r1), 32'(c_acc && c_g == 1));
    check("out_valid",  32'(ov), 32'(m_valid));
    check("out_data",   od, m_data);
    check("out_src",    32'(os), 32'(m_src));
    check("locked",     32'(lk), 32'(m_owner >= 0));
    check("beat_count", 32'(bc), 32'((m_cnt > 255) ? 255 : m_cnt));
    check("small_count", 32'(s_bc), 32'((m_cnt > 3) ? 3 : m_cnt));
    check("small_data", s_od, m_data);
    check("lockmax1_locked", 32'(o_lk), 32'(0));

    if (rst) begin
      if (c_acc) begin
        c_d = (c_g == 1) ? d1 : d0;
        m_data = c_d; m_src = c_g; m_valid = 1; m_last = c_g; m_cnt++;
        if (c_d[31]) begin
          c_n = (m_owner == c_g) ? m_runs + 1 : 1;
          if (c_n < 4) begin m_owner = c_g; m_runs = c_n; end
          else         begin m_owner = -1;  m_runs = 0;   end
        end else begin
          m_owner = -1; m_runs = 0;
        end
      end else begin
        if (m_valid == 1 && ordy) m_valid = 0;
        if ((m_valid == 0 || ordy) && m_owner >= 0) begin m_owner = -1; m_runs = 0; end
      end
    end
  end

  task automatic drive(input bit a, input logic [31:0] da, input bit b, input logic [31:0] db,
                       input bit r);
    v0 = a; d0 = da; v1 = b; d1 = db; ordy = r;
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 1);
    cyc(3);
    check("rst_valid", 32'(ov), 0);
    check("rst_count", 32'(bc), 0);
    rst = 1'b1;

    // Alternating ties, req0 first
    drive(1, 32'h1, 1, 32'h2, 1);
    check("t1_first_ready0", 32'(r0), 1);
    check("t1_first_ready1", 32'(r1), 0);
    cyc(1);
    check("t1_data0", od, 32'h1);
    check("t1_src0", 32'(os), 0);
    check("t1_count1", 32'(bc), 1);
    cyc(1);
    check("t1_data1", od, 32'h2);
    check("t1_src1", 32'(os), 1);
    check("t1_count2", 32'(bc), 2);
    cyc(2);
    check("t1_count4", 32'(bc), 4);
    drive(0, 0, 0, 0, 1);
    cyc(1);
    check("t1_drained", 32'(ov), 0);
    check("t1_data_hold", od, 32'h2);

    // Locked run with forced release on the 4th beat
    drive(1, 32'h8000_0001, 1, 32'h2, 1);
    cyc(1);
    check("t2_locked", 32'(lk), 1);
    check("t2_hold_r0", 32'(r0), 1);
    check("t2_hold_r1", 32'(r1), 0);
    check("t2_count5", 32'(bc), 5);
    cyc(3);
    check("t2_released", 32'(lk), 0);
    check("t2_src_last", 32'(os), 0);
    check("t2_count8", 32'(bc), 8);
    check("t2_next_r1", 32'(r1), 1);
    cyc(1);
    check("t2_req1_won", 32'(os), 1);
    check("t2_req1_data", od, 32'h2);
    cyc(1);
    check("t2_relock", 32'(lk), 1);
    check("t2_count10", 32'(bc), 10);

    // Owner drops valid for one cycle
    drive(0, 32'h8000_0001, 1, 32'h2, 1);
    check("t3_r1_granted", 32'(r1), 1);
    check("t3_r0_idle", 32'(r0), 0);
    cyc(1);
    check("t3_src1", 32'(os), 1);
    check("t3_unlocked", 32'(lk), 0);
    check("t3_count11", 32'(bc), 11);
    drive(0, 0, 0, 0, 1);

    // Backpressure then drain+accept in one cycle
    drive(1, 32'h11, 0, 0, 1);
    cyc(1);
    check("t4_data", od, 32'h11);
    drive(1, 32'h22, 0, 0, 0);
    check("t4_stall_r0", 32'(r0), 0);
    cyc(5);
    check("t4_stable_data", od, 32'h11);
    check("t4_stable_valid", 32'(ov), 1);
    check("t4_stable_count", 32'(bc), 12);
    check("t4_still_stalled", 32'(r0), 0);
    drive(1, 32'h22, 0, 0, 1);
    check("t4_release_r0", 32'(r0), 1);
    cyc(1);
    check("t4_new_data", od, 32'h22);
    check("t4_count13", 32'(bc), 13);

    // Async reset mid-lock with a beat in the slot
    drive(1, 32'h8000_0005, 0, 0, 1);
    cyc(1);
    check("t5_locked", 32'(lk), 1);
    check("t5_slot_full", 32'(ov), 1);
    drive(1, 32'h8000_0005, 0, 0, 0);
    #1 rst = 1'b0;
    #1;
    check("t5_rst_valid", 32'(ov), 0);
    check("t5_rst_locked", 32'(lk), 0);
    check("t5_rst_count", 32'(bc), 0);
    check("t5_rst_small", 32'(s_bc), 0);
    check("t5_rst_ready", 32'(r0), 0);
    check("t5_rst_data", od, 0);
    cyc(2);
    rst = 1'b1;
    drive(1, 32'h7, 1, 32'h8, 1);
    check("t5_tie_r0", 32'(r0), 1);

    // Saturating 2-bit counter: 1,2,3,3,3
    cyc(1);
    check("t5_first_src", 32'(os), 0);
    check("t5_first_data", od, 32'h7);
    check("t6_sc1", 32'(s_bc), 1);
    cyc(1);
    check("t6_sc2", 32'(s_bc), 2);
    cyc(1);
    check("t6_sc3", 32'(s_bc), 3);
    cyc(1);
    check("t6_sc3b", 32'(s_bc), 3);
    check("t6_big4", 32'(bc), 4);
    cyc(1);
    check("t6_sc3c", 32'(s_bc), 3);
    check("t6_big5", 32'(bc), 5);

    drive(0, 0, 0, 0, 1);
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
